stream_rr_arb: RTL and testbench
================================

Name: stream_rr_arb

Overview:
- Round-robin arbiter that merges N byte-stream sources onto one stream sink, e.g. several producers sharing the UART TX path or an inc/transform stage.
- Same stall-based handshake as our StreamBus stages: a registered output stage that advances only when the sink is ready.
- A grant is held for a burst of up to MAX_BURST beats, then passed to the next requester.

Parameters:
- N, 4, number of sources; legal range 2..8.
- W, 8, data width per beat.
- MAX_BURST, 4, maximum beats per grant; legal range 1..255.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous active-low reset.
- in_data  in  N*W  source data; source i occupies bits [i*W +: W].
- in_valid  in  N  per-source valid.
- in_ready  out  N  per-source ready.
- out_data  out  W  registered sink data.
- out_valid  out  1  registered sink valid.
- out_ready  in  1  sink ready.
- out_src  out  $clog2(N)  registered index of the source that produced out_data.

Behaviour:
- Reset (rst=0, asynchronous):
  - out_valid=0, out_data=0, out_src=0.
  - state=IDLE, grant=0, ptr=0, beat count=0.
- Stall rule: while out_ready=0, all registers hold, in_ready is all zero, and no state change occurs.
- States:
  - IDLE: in_ready=0.
    - If out_ready=1 and any in_valid is set, select the first set index scanning ptr, ptr+1 … wrapping mod N.
    - Load grant with that index, clear count, go to GRANT.
    - If no in_valid is set, stay in IDLE.
  - GRANT: in_ready[grant]=out_ready; all other bits of in_ready are 0.
    - Accepted beat (in_valid[grant] & out_ready): count++.
    - If count==MAX_BURST-1 on an accepted beat, go to IDLE and set ptr=(grant+1) mod N.
    - If out_ready=1 and in_valid[grant]=0, go to IDLE and set ptr=(grant+1) mod N. The grant is released on a gap.
- Output stage, on each cycle with out_ready=1:
  - out_valid <= (state==GRANT) & in_valid[grant].
  - out_data <= in_data[grant].
  - out_src <= grant.
- Latency and overhead:
  - Latency from an accepted beat to out_valid is 1 cycle.
  - Each grant costs 1 IDLE bubble cycle.
  - Sustained throughput is MAX_BURST/(MAX_BURST+1) with all sources busy.
- Fairness: a source that keeps in_valid=1 is served within (N-1)*(MAX_BURST+1)+1 arbitration cycles.
- Edge cases:
  - MAX_BURST=1: one beat per grant, then IDLE.
  - Pointer wrap: grant=N-1 gives ptr=0.
  - A source dropping valid on the same cycle it would receive a grant is not granted, because selection samples the current in_valid.
  - Reset mid-burst: the burst is abandoned and the next grant starts from ptr=0.
  - An unaccepted out_valid beat is held stable while out_ready=0.

Optional Feature:
- Macro: STREAM_ARB_STATS_EN.
- Defined:
  - Adds an output port beat_cnt of width N*16. Slot i holds the count of accepted beats from source i.
  - Counters increment on each in_valid[i]&in_ready[i] and saturate at 16'hFFFF.
  - Counters clear on reset.
  - Adds an input port stats_clr (1 bit) that synchronously zeroes all counters. Clear has priority over a same-cycle increment.
- Undefined: neither port exists and no counter logic is generated.

Test Plan:
- Single source: N=4, MAX_BURST=4, out_ready=1; source 2 sends 8'h10..8'h17 continuously.
  - Output is 10,11,12,13, one bubble, 14..17, with out_src=2 throughout.
- All four sources valid continuously, MAX_BURST=4.
  - Grant order is 0,1,2,3,0; each burst is exactly 4 beats with 1 bubble between bursts.
- Backpressure: out_ready=0 for 5 cycles mid-burst.
  - out_data, out_valid and out_src hold; in_ready is 0 throughout.
  - The burst resumes with the correct remaining beat count.
- Gap release: source 1 deasserts valid after 2 of 4 beats while source 3 is waiting.
  - The next grant goes to source 3.
  - ptr becomes 2, so a waiting source 2 would win first.
- Reset during a burst: assert rst low asynchronously.
  - out_valid goes to 0 immediately.
  - After release, the first grant scans from index 0.
- STATS_EN: send 3 beats from source 0 and 5 beats from source 3.
  - beat_cnt slot 0 = 3, slot 3 = 5.
  - stats_clr pulsed together with an accepted beat leaves all slots at 0.

Source files
------------

// File: rtl/stream_rr_arb.sv
// Round-robin merge of N byte-stream sources onto one registered, stall-based sink.
// Optional per-source accepted-beat counters are built when STREAM_ARB_STATS_EN is defined.
module stream_rr_arb #(
  parameter int N         = 4,
  parameter int W         = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*W-1:0]       in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [W-1:0]         out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] out_src
`ifdef STREAM_ARB_STATS_EN
  ,
  input  logic                 stats_clr,
  output logic [N*16-1:0]      beat_cnt
`endif
);

  localparam int GW = $clog2(N);
  localparam int CW = 8;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state;
  logic [GW-1:0]   grant;
  logic [GW-1:0]   ptr;
  logic [CW-1:0]   cnt;

  logic [GW:0]     sel;
  logic [W-1:0]    gnt_data;
  logic            gnt_valid;

  // Successor of a source index, wrapping at N (N need not be a power of two).
  function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] idx);
    if (idx == GW'(N - 1)) return '0;
    return idx + GW'(1);
  endfunction

  // Scan v starting at p, wrapping mod N; MSB of the result flags a hit.
  function automatic logic [GW:0] pick(input logic [N-1:0] v, input logic [GW-1:0] p);
    logic [GW:0] s;
    logic [GW:0] res;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      s = {1'b0, p} + (GW+1)'(k);
      if (s >= (GW+1)'(N)) s = s - (GW+1)'(N);
      if (v[s[GW-1:0]]) res = {1'b1, s[GW-1:0]};
    end
    return res;
  endfunction

  assign sel = pick(in_valid, ptr);

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == GW'(i)) gnt_data = in_data[i*W +: W];
    end
  end

  assign gnt_valid = in_valid[grant];

  always_comb begin
    in_ready = '0;
    if (state == GRANT) in_ready[grant] = out_ready;
  end

  // Stage boundary: arbitration state and registered sink stage, both frozen while out_ready=0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      grant     <= '0;
      ptr       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (out_ready) begin
      out_valid <= (state == GRANT) & gnt_valid;
      out_data  <= gnt_data;
      out_src   <= grant;
      case (state)
        IDLE: begin
          if (sel[GW]) begin
            grant <= sel[GW-1:0];
            cnt   <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (gnt_valid) begin
            if (cnt == CW'(MAX_BURST - 1)) begin
              state <= IDLE;
              ptr   <= next_idx(grant);
            end else begin
              cnt <= cnt + CW'(1);
            end
          end else begin
            // Source went quiet mid-burst: release the grant rather than wait.
            state <= IDLE;
            ptr   <= next_idx(grant);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef STREAM_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) return v;
    return v + 16'd1;
  endfunction

  for (genvar i = 0; i < N; i++) begin : g_stats
    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q <= '0;
      end else if (stats_clr) begin
        cnt_q <= '0;
      end else if (in_valid[i] & in_ready[i]) begin
        cnt_q <= sat_inc(cnt_q);
      end
    end

    assign beat_cnt[i*16 +: 16] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_stream_rr_arb.sv
// Directed bench for stream_rr_arb: scripted sources, expected-beat queue, cycle-span checks.
module tb_stream_rr_arb;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [1:0]     out_src;
`ifdef STREAM_ARB_STATS_EN
  logic           stats_clr;
  logic [N*16-1:0] beat_cnt;
`endif

  always #5 clk = ~clk;

  stream_rr_arb #(.N(N), .W(W), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src)
`ifdef STREAM_ARB_STATS_EN
    ,
    .stats_clr (stats_clr),
    .beat_cnt  (beat_cnt)
`endif
  );

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] s;
  } beat_t;

  beat_t      sb[$];
  logic [7:0] src_mem [N][16];
  int         src_len [N];
  int         src_pos [N];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         pops = 0;
  int         first_cyc = -1;
  int         last_cyc = -1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (src_pos[i] < src_len[i]) begin
        in_valid[i]       = 1'b1;
        in_data[i*W +: W] = src_mem[i][src_pos[i]];
      end else begin
        in_valid[i]       = 1'b0;
        in_data[i*W +: W] = '0;
      end
    end
  endtask

  task automatic load_src(input int i, input logic [7:0] base, input int len);
    for (int k = 0; k < len; k++) src_mem[i][k] = base + 8'(k);
    src_len[i] = len;
    src_pos[i] = 0;
  endtask

  task automatic push(input logic [7:0] d, input logic [1:0] s);
    beat_t e;
    e.d = d;
    e.s = s;
    sb.push_back(e);
  endtask

  task automatic tick();
    logic [N-1:0] acc;
    beat_t e;
    @(negedge clk);
    cyc++;
    acc = in_valid & in_ready;
    if (out_valid && out_ready) begin
      chk("beat_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_data", 32'(out_data), 32'(e.d));
        chk("out_src", 32'(out_src), 32'(e.s));
      end
      pops++;
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) src_pos[i]++;
    drive();
  endtask

  task automatic run(input int max_cycles);
    int n;
    n = 0;
    drive();
    while (sb.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  task automatic reset_dut();
    rst       = 1'b0;
    out_ready = 1'b1;
`ifdef STREAM_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    for (int i = 0; i < N; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
    end
    sb.delete();
    drive();
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_src", 32'(out_src), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b1;
    first_cyc = -1;
    last_cyc  = -1;
    pops      = 0;
  endtask

  initial begin
    int n;
    in_data  = '0;
    in_valid = '0;

    // Single source: two bursts of 4 with one bubble between.
    reset_dut();
    load_src(2, 8'h10, 8);
    for (int k = 0; k < 8; k++) push(8'h10 + 8'(k), 2'd2);
    run(60);
    chk("single_span", last_cyc - first_cyc, 8);

    // All sources busy: order 0,1,2,3 twice, 4 beats each, one bubble per grant.
    reset_dut();
    for (int i = 0; i < N; i++) load_src(i, 8'(i * 16), 8);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++)
        for (int k = 0; k < 4; k++) push(8'(i * 16 + r * 4 + k), 2'(i));
    run(200);
    chk("all_span", last_cyc - first_cyc, 38);

    // Backpressure mid-burst; burst count must survive the stall.
    reset_dut();
    load_src(0, 8'hA0, 6);
    load_src(1, 8'hB0, 1);
    for (int k = 0; k < 4; k++) push(8'hA0 + 8'(k), 2'd0);
    push(8'hB0, 2'd1);
    push(8'hA4, 2'd0);
    push(8'hA5, 2'd0);
    drive();
    n = 0;
    while (pops < 2 && n < 20) begin
      tick();
      n++;
    end
    chk("bp_pre_beats", pops, 2);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(out_valid), 1);
      chk("bp_hold_data", 32'(out_data), 32'h A2);
      chk("bp_hold_src", 32'(out_src), 0);
      chk("bp_in_ready", 32'(in_ready), 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    run(40);

    // Gap release hands over to the waiting source 3.
    reset_dut();
    load_src(1, 8'h21, 2);
    load_src(3, 8'h31, 2);
    push(8'h21, 2'd1);
    push(8'h22, 2'd1);
    push(8'h31, 2'd3);
    push(8'h32, 2'd3);
    run(40);

    // Gap release sets ptr to 2, so source 2 beats source 3.
    reset_dut();
    load_src(1, 8'h41, 2);
    load_src(2, 8'h51, 1);
    load_src(3, 8'h61, 2);
    push(8'h41, 2'd1);
    push(8'h42, 2'd1);
    push(8'h51, 2'd2);
    push(8'h61, 2'd3);
    push(8'h62, 2'd3);
    run(40);

    // Asynchronous reset in the middle of a source-2 burst (ptr is 1 at that moment).
    reset_dut();
    load_src(0, 8'hC0, 1);
    load_src(2, 8'hD0, 8);
    push(8'hC0, 2'd0);
    for (int k = 0; k < 8; k++) push(8'hD0 + 8'(k), 2'd2);
    drive();
    n = 0;
    while (pops < 3 && n < 20) begin
      tick();
      n++;
    end
    chk("mid_pre_beats", pops, 3);
    #3;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_data", 32'(out_data), 0);
    chk("mid_rst_src", 32'(out_src), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    for (int i = 0; i < N; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
    end
    sb.delete();
    drive();
    @(posedge clk);
    #1;
    rst = 1'b1;
    load_src(0, 8'hE0, 1);
    load_src(1, 8'hF0, 1);
    push(8'hE0, 2'd0);
    push(8'hF0, 2'd1);
    run(20);

`ifdef STREAM_ARB_STATS_EN
    // Per-source beat counters, then a clear that coincides with an accepted beat.
    reset_dut();
    load_src(0, 8'h01, 3);
    load_src(3, 8'h31, 5);
    for (int k = 0; k < 3; k++) push(8'h01 + 8'(k), 2'd0);
    for (int k = 0; k < 4; k++) push(8'h31 + 8'(k), 2'd3);
    push(8'h35, 2'd3);
    run(60);
    chk("stats_slot0", 32'(beat_cnt[0 +: 16]), 3);
    chk("stats_slot1", 32'(beat_cnt[16 +: 16]), 0);
    chk("stats_slot2", 32'(beat_cnt[32 +: 16]), 0);
    chk("stats_slot3", 32'(beat_cnt[48 +: 16]), 5);
    load_src(1, 8'h77, 1);
    push(8'h77, 2'd1);
    stats_clr = 1'b1;
    drive();
    n = 0;
    while (src_pos[1] < 1 && n < 20) begin
      tick();
      n++;
    end
    stats_clr = 1'b0;
    chk("stats_clr_accept", src_pos[1], 1);
    run(10);
    for (int i = 0; i < N; i++) chk("stats_cleared", 32'(beat_cnt[i*16 +: 16]), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
